// File: rtl/traffic_pkg.sv
// Shared lamp encodings and phase codes for the intersection sequencer.
// NIGHT_FLASH_EN adds the FLASH phase code.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    RED    = 2'b01,
    YELLOW = 2'b10,
    OFF    = 2'b11
  } light_t;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    RED1  = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    RED2  = 3'd5
`ifdef NIGHT_FLASH_EN
    , FLASH = 3'd6
`endif
  } phase_t;

  function automatic logic is_all_red(input phase_t p);
    return (p == RED1) || (p == RED2);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase tick counter: synchronous clear wins over tick, saturates at all-ones.
module phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clear,
  input  logic             tick,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      cnt_reg <= '0;
    end else if (tick && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection phase sequencer with latched pedestrian walk in all-red.
// Optional night flashing mode is enabled by defining NIGHT_FLASH_EN.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int CNT_W     = 6,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_TA,
  input  logic       i_TB,
  input  logic       i_M,
  input  logic       i_ped_req,
`ifdef NIGHT_FLASH_EN
  input  logic       i_night,
`endif
  output logic [1:0] o_LA,
  output logic [1:0] o_LB,
  output logic       o_walk,
  output logic       o_ped_ack,
  output logic [2:0] o_phase
);

  generate
    if (!((MIN_GREEN <= MAX_GREEN) && (MAX_GREEN < (1 << CNT_W)) && (WALK_T < (1 << CNT_W))
          && (YELLOW_T < (1 << CNT_W)) && (ALLRED_T < (1 << CNT_W)))) begin : g_bad_cfg
      $error("traffic_phase_sequencer: timing constants do not fit the phase counter");
    end
  endgenerate

  localparam logic [CNT_W-1:0] MIN_G  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_G  = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] YEL_C  = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] RED_C  = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] WALK_C = CNT_W'(WALK_T);

  phase_t           phase_reg, phase_next;
  logic             ped_pend_reg, walk_active_reg, ped_ack_reg;
  logic             walk_start, walk_end, cnt_clear;
  logic [CNT_W-1:0] cnt;
  light_t           la, lb;
`ifdef NIGHT_FLASH_EN
  logic             flash_reg;
`endif

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (i_clk),
    .srst  (i_rst),
    .clear (cnt_clear),
    .tick  (i_tick),
    .cnt   (cnt)
  );

  always_comb begin
    phase_next = phase_reg;
    walk_end   = 1'b0;
    case (phase_reg)
      A_GRN: if ((cnt >= MIN_G) && (ped_pend_reg || (i_TB && (!i_TA || (cnt >= MAX_G)))))
               phase_next = A_YEL;
      A_YEL: if (cnt == YEL_C) phase_next = RED1;
      RED1, RED2: begin
`ifdef NIGHT_FLASH_EN
        if (i_night) begin
          phase_next = FLASH;
        end else
`endif
        if (walk_active_reg) begin
          walk_end = (cnt == WALK_C);
        end else if (cnt == RED_C) begin
          phase_next = (phase_reg == RED1) ? B_GRN : A_GRN;
        end
      end
      B_GRN: if (!i_M && (cnt >= MIN_G) && (!i_TB || ped_pend_reg || ((cnt >= MAX_G) && i_TA)))
               phase_next = B_YEL;
      B_YEL: if (cnt == YEL_C) phase_next = RED2;
`ifdef NIGHT_FLASH_EN
      FLASH: if (!i_night) phase_next = RED2;
`endif
      default: phase_next = RED2;
    endcase

    // A walk is granted only on the edge that enters an all-red phase.
    walk_start = is_all_red(phase_next) && (phase_next != phase_reg) && ped_pend_reg;
    cnt_clear  = (phase_next != phase_reg) || walk_end;
  end

  always_comb begin
    la = RED;
    lb = RED;
    case (phase_reg)
      A_GRN: la = GREEN;
      A_YEL: la = YELLOW;
      B_GRN: lb = GREEN;
      B_YEL: lb = YELLOW;
`ifdef NIGHT_FLASH_EN
      FLASH: la = flash_reg ? OFF : YELLOW;
`endif
      default: begin
        la = RED;
        lb = RED;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_reg       <= RED2;
      ped_pend_reg    <= 1'b0;
      walk_active_reg <= 1'b0;
      ped_ack_reg     <= 1'b0;
`ifdef NIGHT_FLASH_EN
      flash_reg       <= 1'b0;
`endif
    end else begin
      phase_reg    <= phase_next;
      ped_ack_reg  <= walk_start;
      ped_pend_reg <= walk_start ? i_ped_req : (ped_pend_reg | i_ped_req);
      // Leaving all-red (normally or into FLASH) always ends any walk.
      if (walk_start) begin
        walk_active_reg <= 1'b1;
      end else if (walk_end || (phase_next != phase_reg)) begin
        walk_active_reg <= 1'b0;
      end
`ifdef NIGHT_FLASH_EN
      if (phase_reg != FLASH) begin
        flash_reg <= 1'b0;
      end else if (i_tick) begin
        flash_reg <= ~flash_reg;
      end
`endif
    end
  end

  assign o_LA      = la;
  assign o_LB      = lb;
  assign o_walk    = walk_active_reg;
  assign o_ped_ack = ped_ack_reg;
  assign o_phase   = phase_reg;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: phase durations in ticks, lamps, walk and reset.
module tb_traffic_phase_sequencer;

  localparam logic [2:0] PH_A_GRN = 3'd0, PH_A_YEL = 3'd1, PH_RED1 = 3'd2;
  localparam logic [2:0] PH_B_GRN = 3'd3, PH_B_YEL = 3'd4, PH_RED2 = 3'd5;
  localparam logic [1:0] L_GREEN = 2'b00, L_RED = 2'b01, L_YELLOW = 2'b10;

  logic       i_clk = 1'b0;
  logic       i_rst, i_tick, i_TA, i_TB, i_M, i_ped_req;
`ifdef NIGHT_FLASH_EN
  logic       i_night;
`endif
  logic [1:0] o_LA, o_LB;
  logic       o_walk, o_ped_ack;
  logic [2:0] o_phase;

  int checks = 0;
  int errors = 0;
  int ack_cycles = 0;
  int walk_ticks = 0;

  always #5 i_clk = ~i_clk;

  traffic_phase_sequencer dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_tick    (i_tick),
    .i_TA      (i_TA),
    .i_TB      (i_TB),
    .i_M       (i_M),
    .i_ped_req (i_ped_req),
`ifdef NIGHT_FLASH_EN
    .i_night   (i_night),
`endif
    .o_LA      (o_LA),
    .o_LB      (o_LB),
    .o_walk    (o_walk),
    .o_ped_ack (o_ped_ack),
    .o_phase   (o_phase)
  );

  // Timebase: one tick every fourth clock, changed on the falling edge.
  initial begin
    int cyc;
    cyc    = 0;
    i_tick = 1'b0;
    forever begin
      @(negedge i_clk);
      cyc++;
      i_tick = ((cyc % 4) == 0);
    end
  end

  always @(negedge i_clk) begin
    #2;
    if (!i_rst) begin
      if (o_ped_ack === 1'b1) ack_cycles++;
      if ((o_walk === 1'b1) && i_tick) walk_ticks++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int t;
    int guard;
    t = 0;
    guard = 0;
    while ((t < n) && (guard < 1000)) begin
      if (i_tick) t++;
      step();
      guard++;
    end
  endtask

  // Count ticks seen by the DUT until o_phase changes; drops any pedestrian pulse after one cycle.
  task automatic measure(input int budget, output int ticks);
    logic [2:0] ph;
    bit done;
    ph    = o_phase;
    ticks = 0;
    done  = 1'b0;
    for (int c = 0; (c < budget) && !done; c++) begin
      if (i_tick) ticks++;
      step();
      i_ped_req = 1'b0;
      if (o_phase != ph) done = 1'b1;
    end
    check_val("phase_exit_in_budget", 32'(done), 32'd1);
  endtask

  initial begin
    int t;
    int changes;
    int ack_base, walk_base;

    i_rst = 1'b1; i_TA = 1'b1; i_TB = 1'b0; i_M = 1'b0; i_ped_req = 1'b0;
`ifdef NIGHT_FLASH_EN
    i_night = 1'b0;
`endif
    repeat (3) step();
    check_val("reset_phase", 32'(o_phase), 32'(PH_RED2));
    check_val("reset_LA", 32'(o_LA), 32'(L_RED));
    check_val("reset_LB", 32'(o_LB), 32'(L_RED));
    check_val("reset_walk", 32'(o_walk), 32'd0);
    check_val("reset_ack", 32'(o_ped_ack), 32'd0);
    i_rst = 1'b0;

    measure(100, t);
    check_val("red2_after_reset_ticks", 32'(t), 32'd1);
    check_val("a_grn_phase", 32'(o_phase), 32'(PH_A_GRN));
    check_val("a_grn_LA", 32'(o_LA), 32'(L_GREEN));
    check_val("a_grn_LB", 32'(o_LB), 32'(L_RED));

    // Demand swaps to road B after two ticks of A green.
    wait_ticks(2);
    i_TA = 1'b0; i_TB = 1'b1;
    measure(100, t);
    check_val("a_grn_total_ticks", 32'(t + 2), 32'd5);
    check_val("a_yel_phase", 32'(o_phase), 32'(PH_A_YEL));
    check_val("a_yel_LA", 32'(o_LA), 32'(L_YELLOW));
    measure(100, t);
    check_val("a_yel_ticks", 32'(t), 32'd3);
    check_val("red1_phase", 32'(o_phase), 32'(PH_RED1));
    measure(100, t);
    check_val("red1_ticks", 32'(t), 32'd1);
    check_val("b_grn_phase", 32'(o_phase), 32'(PH_B_GRN));
    check_val("b_grn_LA", 32'(o_LA), 32'(L_RED));
    check_val("b_grn_LB", 32'(o_LB), 32'(L_GREEN));

    // Both roads busy: each green runs to the maximum.
    i_TA = 1'b1; i_TB = 1'b1;
    measure(200, t);
    check_val("b_grn_max_ticks", 32'(t), 32'd20);
    check_val("b_yel_LB", 32'(o_LB), 32'(L_YELLOW));
    measure(100, t);
    check_val("b_yel_ticks", 32'(t), 32'd3);
    measure(100, t);
    check_val("red2_ticks", 32'(t), 32'd1);
    measure(200, t);
    check_val("a_grn_max_ticks", 32'(t), 32'd20);
    measure(100, t);
    measure(100, t);
    check_val("back_to_b_grn", 32'(o_phase), 32'(PH_B_GRN));

    // Manual hold keeps B green with no B traffic.
    i_M = 1'b1; i_TB = 1'b0;
    changes = 0;
    repeat (200) begin
      step();
      if (o_phase != PH_B_GRN) changes++;
    end
    check_val("manual_hold_changes", 32'(changes), 32'd0);
    i_M = 1'b0;
    step();
    check_val("manual_release_phase", 32'(o_phase), 32'(PH_B_YEL));
    measure(100, t);
    check_val("b_yel_after_release_ticks", 32'(t), 32'd3);
    measure(100, t);
    check_val("a_grn_rest_entry", 32'(o_phase), 32'(PH_A_GRN));

    // A rests green for 100 ticks with no competing demand.
    changes = 0;
    repeat (400) begin
      step();
      if (o_phase != PH_A_GRN) changes++;
    end
    check_val("a_rest_changes", 32'(changes), 32'd0);
    check_val("a_rest_LA", 32'(o_LA), 32'(L_GREEN));

    // Cycle around to a fresh A green for the pedestrian case.
    i_TB = 1'b1;
    step();
    check_val("saturated_a_grn_exit", 32'(o_phase), 32'(PH_A_YEL));
    measure(100, t);
    measure(100, t);
    i_TB = 1'b0;
    measure(100, t);
    check_val("b_grn_no_traffic_ticks", 32'(t), 32'd5);
    measure(100, t);
    measure(100, t);
    check_val("ped_start_phase", 32'(o_phase), 32'(PH_A_GRN));

    i_TA = 1'b0; i_TB = 1'b0;
    ack_base  = ack_cycles;
    walk_base = walk_ticks;
    i_ped_req = 1'b1;
    measure(100, t);
    check_val("ped_a_grn_ticks", 32'(t), 32'd5);
    measure(100, t);
    check_val("ped_red1_phase", 32'(o_phase), 32'(PH_RED1));
    check_val("ped_ack_on_entry", 32'(o_ped_ack), 32'd1);
    check_val("walk_on_entry", 32'(o_walk), 32'd1);
    wait_ticks(2);
    i_ped_req = 1'b1;
    i_TB = 1'b1;
    measure(200, t);
    check_val("red1_walk_ticks", 32'(t + 2), 32'd9);
    check_val("ped_ack_cycles", 32'(ack_cycles - ack_base), 32'd1);
    check_val("walk_ticks", 32'(walk_ticks - walk_base), 32'd8);
    check_val("after_walk_phase", 32'(o_phase), 32'(PH_B_GRN));

    // Request made during the walk forces B off at minimum green.
    measure(100, t);
    check_val("b_grn_ped_ticks", 32'(t), 32'd5);
    measure(100, t);
    check_val("red2_walk_phase", 32'(o_phase), 32'(PH_RED2));
    check_val("red2_walk_on", 32'(o_walk), 32'd1);
    check_val("red2_ack_on", 32'(o_ped_ack), 32'd1);

    wait_ticks(3);
    i_rst = 1'b1;
    step();
    check_val("midwalk_rst_walk", 32'(o_walk), 32'd0);
    check_val("midwalk_rst_LA", 32'(o_LA), 32'(L_RED));
    check_val("midwalk_rst_LB", 32'(o_LB), 32'(L_RED));
    check_val("midwalk_rst_phase", 32'(o_phase), 32'(PH_RED2));
    i_rst = 1'b0;
    i_TA = 1'b1; i_TB = 1'b0;
    measure(100, t);
    check_val("post_rst_red2_ticks", 32'(t), 32'd1);
    walk_base = walk_ticks;
    changes = 0;
    repeat (160) begin
      step();
      if (o_phase != PH_A_GRN) changes++;
    end
    check_val("post_rst_no_pending_ped", 32'(changes), 32'd0);
    check_val("post_rst_walk_ticks", 32'(walk_ticks - walk_base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Timed scheduler for a two-road intersection: road A, the main road, and road B, the side road. It sequences green/yellow/all-red phases from a slow tick, arbitrates green time between the road-A and road-B traffic sensors, and serves a latched pedestrian request with a walk interval inside all-red. Its outputs drive lamp drivers directly, using the team's standard light encoding.

Parameters:
CNT_W, 6, width of phase tick counter
MIN_GREEN, 5, minimum green ticks per road
MAX_GREEN, 20, green ticks after which competing demand forces a change
YELLOW_T, 3, yellow duration in ticks
ALLRED_T, 1, all-red clearance in ticks
WALK_T, 8, walk duration in ticks (all-red extended)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_tick  in  1  one-cycle timebase strobe
i_TA  in  1  traffic present on road A
i_TB  in  1  traffic present on road B
i_M  in  1  manual hold; keeps road B green
i_ped_req  in  1  pedestrian button pulse
o_LA  out  2  road A lamp: GREEN=00 RED=01 YELLOW=10 OFF=11
o_LB  out  2  road B lamp, same encoding
o_walk  out  1  walk lamp
o_ped_ack  out  1  one-cycle pulse when a walk interval starts
o_phase  out  3  current phase code, for debug

Behaviour:
- Interface: one clock, i_clk. i_rst is synchronous and active-high.
- Phases:
  - A_GRN=0, A_YEL=1, RED1=2, B_GRN=3, B_YEL=4, RED2=5.
  - FLASH=6 exists only with the optional feature.
- Registers: phase, cnt[CNT_W-1:0], ped_pend, walk_active.
- On reset:
  - phase=RED2, cnt=0, ped_pend=0, walk_active=0.
  - Outputs: o_LA=RED, o_LB=RED, o_walk=0, o_ped_ack=0.
- Outputs decode from the registered phase with no further latency:
  - A_GRN: LA=GREEN, LB=RED.
  - A_YEL: LA=YELLOW, LB=RED.
  - B_GRN: LA=RED, LB=GREEN.
  - B_YEL: LA=RED, LB=YELLOW.
  - RED1/RED2: both RED.
- Counter:
  - Cleared to 0 on the cycle a phase change is registered; an i_tick in that cycle is dropped.
  - Otherwise increments on i_tick and saturates at all-ones.
- Transitions are evaluated combinationally from phase/cnt/inputs and take effect at the next i_clk edge.
- A_GRN -> A_YEL when cnt>=MIN_GREEN and either:
  - ped_pend=1, or
  - i_TB=1 and (i_TA=0 or cnt>=MAX_GREEN).
  - With no B demand and no pedestrian, road A rests green indefinitely.
- A_YEL -> RED1 when cnt==YELLOW_T.
- RED1 -> B_GRN when cnt==ALLRED_T and walk_active=0.
- B_GRN -> B_YEL when i_M=0, cnt>=MIN_GREEN, and (i_TB=0 or ped_pend=1 or (cnt>=MAX_GREEN and i_TA=1)).
  - i_M=1 holds B_GRN regardless of cnt.
- B_YEL -> RED2 when cnt==YELLOW_T.
- RED2 -> A_GRN when cnt==ALLRED_T and walk_active=0.
- Pedestrian service:
  - ped_pend sets on i_ped_req and clears only at ack.
  - On entry into RED1 or RED2 with ped_pend=1: o_ped_ack pulses one cycle, walk_active=1, o_walk=1, ped_pend clears and cnt restarts.
  - Walk ends when cnt==WALK_T: walk_active=0 and cnt clears.
  - Normal ALLRED_T timing then resumes.
- i_ped_req in the same cycle as ack, or during walk: ped_pend stays/sets 1 and is served at the next all-red.
- Constants must satisfy MIN_GREEN<=MAX_GREEN<2^CNT_W and WALK_T<2^CNT_W; check with an elaboration-time assertion.
- Reset asserted mid-phase or mid-walk returns immediately, at the next edge, to the reset state.
- Undefined phase codes decode both lamps RED and go to RED2.

Optional Feature:
Macro NIGHT_FLASH_EN.
- Defined:
  - Adds input i_night (1 bit).
  - From RED1 or RED2 with i_night=1, go to FLASH, taking priority over walk.
  - In FLASH, o_LB=RED and o_LA alternates YELLOW/OFF, toggling on each i_tick, starting YELLOW.
  - Pedestrian requests stay latched in FLASH; o_walk=0.
  - FLASH -> RED2 on the cycle after i_night=0.
- Undefined: no i_night port, no FLASH state, and OFF is never driven.

Decomposition:
- Package traffic_pkg: light encodings GREEN/RED/YELLOW/OFF and the phase codes as localparams/typedef.
- Sub-module phase_timer: clear, tick, saturate; parameter CNT_W; output cnt. Instanced once.

Test Plan:
- Reset, then i_tick every 4 cycles, i_TA=1, i_TB=0 -> RED2 for 1 tick, then A_GRN held for 100 ticks; LA=00, LB=01.
- In A_GRN, i_TA=0 and i_TB=1 at tick 2 -> A_YEL at tick 5, RED1 after 3 ticks, B_GRN after 1 more tick.
- i_TA=i_TB=1 -> A green exactly 20 ticks; B green exactly 20 ticks.
- i_M=1 in B_GRN with i_TB=0 for 50 ticks -> stays B_GRN; release -> B_YEL once cnt>=5.
- i_ped_req pulse during A_GRN, no traffic -> A_YEL at cnt=5; o_ped_ack one cycle on RED1 entry; o_walk high for 8 ticks; RED1 lasts 8+1 ticks.
- i_rst pulse mid-walk -> next edge: o_walk=0, both lamps RED, phase=5, ped_pend=0.
